// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks.
// Latency: n/a (types, codes and a helper function only).
// Backpressure: n/a.
//
// Contents: FSM state enum, parity and stop-bit codes, data-bit-count decode.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Parity codes; code 3 also means "no parity".
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Stop-bit codes; code 3 also means "2 stop bits".
  localparam logic [1:0] STOP_1   = 2'd0;
  localparam logic [1:0] STOP_1P5 = 2'd1;
  localparam logic [1:0] STOP_2   = 2'd2;

  // cfg_dbits code 0..3 selects 5..8 data bits.
  function automatic logic [3:0] dbits_count(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous character FIFO with extra-MSB pointers for full/empty detection.
// Latency: a pushed entry is visible at dout (and empty deasserts) one cycle after the push edge.
// Backpressure: push while full is dropped (overflow pulses next cycle) unless a pop happens in the same cycle.
//
// Ports: clk, reset_n (async, active low); push/din write side; pop/dout read side (dout is the head, valid
// when !empty); full, empty, level status; overflow one-cycle pulse after a dropped write.
module uart_tx_fifo #(
  parameter int DBIT_MAX   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [DBIT_MAX-1:0]           din,
  input  logic                          pop,
  output logic [DBIT_MAX-1:0]           dout,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [DBIT_MAX-1:0] mem [FIFO_DEPTH];
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  // Same slot, different wrap bit: writer is a full lap ahead.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a write while full is still taken.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      overflow <= push && !do_push;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, none/even/odd parity, 1/1.5/2 stop) fed by a FIFO.
// Latency: tx falls 2 clk after a write is presented to an idle, empty block; queued frames run back-to-back.
// Backpressure: none on the line; writes to a full FIFO are dropped and flagged by tx_overflow.
//
// Ports: clk, reset_n; s_tick oversampling strobe; tx_din/tx_wr write side; cfg_dbits/cfg_parity/cfg_stop
// frame format (latched per frame); tx line, tx_busy, tx_done_tick, FIFO status tx_full/tx_empty/
// tx_overflow/fifo_level.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX   = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_tick,
  input  logic [DBIT_MAX-1:0]           tx_din,
  input  logic                          tx_wr,
  input  logic [1:0]                    cfg_dbits,
  input  logic [1:0]                    cfg_parity,
  input  logic [1:0]                    cfg_stop,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done_tick,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic                          tx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP1_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(3 * OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);

  uart_state_t         state;
  logic [TW-1:0]       tick_cnt;
  logic [2:0]          bit_cnt;
  logic [DBIT_MAX-1:0] shreg;
  logic                par_acc;
  logic [3:0]          f_nbits;
  logic [1:0]          f_par;
  logic [1:0]          f_stop;

  logic [DBIT_MAX-1:0] fifo_dout;
  logic [TW-1:0]       stop_last;
  logic                stop_end;
  logic                pop;
  logic                par_en;
  logic                par_next;

  uart_tx_fifo #(
    .DBIT_MAX   (DBIT_MAX),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (tx_wr),
    .din      (tx_din),
    .pop      (pop),
    .dout     (fifo_dout),
    .full     (tx_full),
    .empty    (tx_empty),
    .overflow (tx_overflow),
    .level    (fifo_level)
  );

  always_comb begin
    case (f_stop)
      STOP_1:   stop_last = STOP1_LAST;
      STOP_1P5: stop_last = STOP15_LAST;
      default:  stop_last = STOP2_LAST;
    endcase
  end

  assign stop_end = (state == STOP) && s_tick && (tick_cnt == stop_last);
  // Head entry is taken either from idle or on the last stop tick, giving gapless back-to-back frames.
  assign pop      = !tx_empty && ((state == IDLE) || stop_end);
  assign par_en   = (f_par == PAR_EVEN) || (f_par == PAR_ODD);
  assign par_next = par_acc ^ shreg[0];

  assign tx_busy      = (state != IDLE);
  // Marks the cycle holding the final stop tick; busy drops on the following edge if nothing is queued.
  assign tx_done_tick = stop_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      f_nbits  <= 4'd8;
      f_par    <= PAR_NONE;
      f_stop   <= STOP_1;
    end else if (pop) begin
      state    <= START;
      tx       <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= fifo_dout;
      par_acc  <= 1'b0;
      f_nbits  <= dbits_count(cfg_dbits);
      f_par    <= cfg_parity;
      f_stop   <= cfg_stop;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          tick_cnt <= '0;
        end
        START: begin
          if (s_tick) begin
            if (tick_cnt == BIT_LAST) begin
              state    <= DATA;
              tx       <= shreg[0];
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              par_acc  <= par_next;
              shreg    <= shreg >> 1;
              if ({1'b0, bit_cnt} == f_nbits - 4'd1) begin
                bit_cnt <= '0;
                if (par_en) begin
                  state <= PARITY;
                  tx    <= (f_par == PAR_ODD) ? ~par_next : par_next;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                tx      <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (tick_cnt == BIT_LAST) begin
              state    <= STOP;
              tx       <= 1'b1;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          // Final tick with a queued character is handled by the pop branch above.
          if (s_tick) begin
            if (tick_cnt == stop_last) begin
              state    <= IDLE;
              tx       <= 1'b1;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule
